// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with synchronous clear, clamped parallel load,
// and either wrap-around or saturation at the count limits.
module bcd_updown_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  u,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  tc,
  output logic                  err
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] cnt_q, cnt_d;
  logic         tc_q, tc_d;
  logic         err_q, err_d;

  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic [W-1:0] load_clamped;
  logic         inc_carry;
  logic         dec_borrow;
  logic         any_clamp;
  logic [3:0]   inc_dig;
  logic [3:0]   dec_dig;
  logic [3:0]   ld_dig;

  // Ripple carry/borrow through every digit; the final carry/borrow marks the
  // all-9s / all-0s limit, so it doubles as the wrap/blocked indication.
  always_comb begin
    inc_val    = '0;
    dec_val    = '0;
    inc_carry  = 1'b1;
    dec_borrow = 1'b1;
    inc_dig    = '0;
    dec_dig    = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      inc_dig = cnt_q[4*k +: 4];
      dec_dig = cnt_q[4*k +: 4];
      if (inc_carry) begin
        if (inc_dig >= 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = inc_dig + 4'd1;
          inc_carry         = 1'b0;
        end
      end else begin
        inc_val[4*k +: 4] = inc_dig;
      end
      if (dec_borrow) begin
        if (dec_dig == 4'd0) begin
          dec_val[4*k +: 4] = 4'd9;
        end else if (dec_dig > 4'd9) begin
          dec_val[4*k +: 4] = 4'd8;
          dec_borrow        = 1'b0;
        end else begin
          dec_val[4*k +: 4] = dec_dig - 4'd1;
          dec_borrow        = 1'b0;
        end
      end else begin
        dec_val[4*k +: 4] = dec_dig;
      end
    end
  end

  // Clamp any non-decimal load digit to 9 and flag that it happened.
  always_comb begin
    load_clamped = '0;
    any_clamp    = 1'b0;
    ld_dig       = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      ld_dig = load_val[4*k +: 4];
      if (ld_dig > 4'd9) begin
        load_clamped[4*k +: 4] = 4'd9;
        any_clamp              = 1'b1;
      end else begin
        load_clamped[4*k +: 4] = ld_dig;
      end
    end
  end

  // Next state: clr beats load beats en; tc/err are single-cycle flags.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    err_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_clamped;
      err_d = any_clamp;
    end else if (en) begin
      if (!u) begin
        tc_d = inc_carry;
        if (!(inc_carry && SATURATE)) begin
          cnt_d = inc_val;
        end
      end else begin
        tc_d = dec_borrow;
        if (!(dec_borrow && SATURATE)) begin
          cnt_d = dec_val;
        end
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      err_q <= err_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = tc_q;
  assign err = err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: a decimal-integer model predicts each edge for three
// counter configurations driven with shared stimulus.
module tb_bcd_updown_counter;

  typedef struct packed {
    logic [31:0] cnt;
    logic        tc;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, u, clr, load;
  logic [15:0] load_val;

  logic [7:0]  cnt2, cnts;
  logic [15:0] cnt4;
  logic        tc2, err2, tcs, errs, tc4, err4;

  exp_t q2[$];
  exp_t qs[$];
  exp_t q4[$];
  exp_t m2, ms, m4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .u(u), .clr(clr), .load(load),
    .load_val(load_val[7:0]), .cnt(cnt2), .tc(tc2), .err(err2));

  bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b1)) duts (
    .clk(clk), .rst_n(rst_n), .en(en), .u(u), .clr(clr), .load(load),
    .load_val(load_val[7:0]), .cnt(cnts), .tc(tcs), .err(errs));

  bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b0)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .u(u), .clr(clr), .load(load),
    .load_val(load_val), .cnt(cnt4), .tc(tc4), .err(err4));

  function automatic int bcd2int(input logic [31:0] b, input int digits);
    int v = 0;
    for (int k = digits - 1; k >= 0; k--) v = v * 10 + int'(b[4*k +: 4]);
    return v;
  endfunction

  function automatic logic [31:0] int2bcd(input int v, input int digits);
    logic [31:0] r = '0;
    int t = v;
    for (int k = 0; k < digits; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input int digits, input bit sat, input exp_t cur,
                                 input logic e, input logic uu, input logic c,
                                 input logic l, input logic [15:0] lv);
    exp_t r;
    int v, mx;
    logic [3:0] d;
    r = cur;
    r.tc = 1'b0;
    r.err = 1'b0;
    mx = 1;
    for (int k = 0; k < digits; k++) mx = mx * 10;
    mx = mx - 1;
    if (c) begin
      r.cnt = '0;
    end else if (l) begin
      r.cnt = '0;
      for (int k = 0; k < digits; k++) begin
        d = lv[4*k +: 4];
        if (d > 4'd9) begin
          d = 4'd9;
          r.err = 1'b1;
        end
        r.cnt[4*k +: 4] = d;
      end
    end else if (e) begin
      v = bcd2int(cur.cnt, digits);
      if (!uu) begin
        if (v == mx) begin r.tc = 1'b1; v = sat ? mx : 0; end
        else v = v + 1;
      end else begin
        if (v == 0) begin r.tc = 1'b1; v = sat ? 0 : mx; end
        else v = v - 1;
      end
      r.cnt = int2bcd(v, digits);
    end
    return r;
  endfunction

  // Drive one edge's inputs at the falling edge, predict, then settle past the rising edge.
  task automatic drive(input logic e, input logic uu, input logic c, input logic l,
                       input logic [15:0] lv);
    @(negedge clk);
    en = e; u = uu; clr = c; load = l; load_val = lv;
    m2 = model(2, 1'b0, m2, e, uu, c, l, lv); q2.push_back(m2);
    ms = model(2, 1'b1, ms, e, uu, c, l, lv); qs.push_back(ms);
    m4 = model(4, 1'b0, m4, e, uu, c, l, lv); q4.push_back(m4);
    @(posedge clk);
    #1;
  endtask

  task automatic get_exp(output exp_t a, output exp_t b, output exp_t c);
    a = q2.pop_front();
    b = qs.pop_front();
    c = q4.pop_front();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 0; u = 0; clr = 0; load = 0; load_val = '0;
    m2 = '0; ms = '0; m4 = '0;
    #12;
    checks++;
    if ({cnt2, tc2, err2} !== 10'd0) begin
      errors++; $display("FAIL reset dut2: cnt=%h tc=%b err=%b expected 00/0/0", cnt2, tc2, err2);
    end
    checks++;
    if ({cnts, tcs, errs} !== 10'd0) begin
      errors++; $display("FAIL reset duts: cnt=%h tc=%b err=%b expected 00/0/0", cnts, tcs, errs);
    end
    checks++;
    if ({cnt4, tc4, err4} !== 18'd0) begin
      errors++; $display("FAIL reset dut4: cnt=%h tc=%b err=%b expected 0000/0/0", cnt4, tc4, err4);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap_up();
    exp_t a, b, c;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(0, 0, 0, 1, 16'h0098);
      else        drive(1, 0, 0, 0, 16'h0000);
      get_exp(a, b, c);
      checks++;
      if (cnt2 !== a.cnt[7:0] || tc2 !== a.tc || err2 !== a.err) begin
        errors++;
        $display("FAIL wrap_up step %0d: cnt=%h tc=%b err=%b expected cnt=%h tc=%b err=%b",
                 i, cnt2, tc2, err2, a.cnt[7:0], a.tc, a.err);
      end
    end
  endtask

  task automatic test_wrap_down();
    exp_t a, b, c;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(0, 1, 1, 0, 16'h0000);
        1, 2: drive(1, 1, 0, 0, 16'h0000);
        3: drive(0, 1, 0, 1, 16'h0010);
        default: drive(1, 1, 0, 0, 16'h0000);
      endcase
      get_exp(a, b, c);
      checks++;
      if (cnt2 !== a.cnt[7:0] || tc2 !== a.tc || err2 !== a.err) begin
        errors++;
        $display("FAIL wrap_down step %0d: cnt=%h tc=%b err=%b expected cnt=%h tc=%b err=%b",
                 i, cnt2, tc2, err2, a.cnt[7:0], a.tc, a.err);
      end
    end
  endtask

  task automatic test_saturate();
    exp_t a, b, c;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: drive(0, 0, 0, 1, 16'h0099);
        1, 2, 3: drive(1, 0, 0, 0, 16'h0000);
        4: drive(1, 1, 0, 0, 16'h0000);
        5: drive(0, 0, 1, 0, 16'h0000);
        default: drive(1, 1, 0, 0, 16'h0000);
      endcase
      get_exp(a, b, c);
      checks++;
      if (cnts !== b.cnt[7:0] || tcs !== b.tc || errs !== b.err) begin
        errors++;
        $display("FAIL saturate step %0d: cnt=%h tc=%b err=%b expected cnt=%h tc=%b err=%b",
                 i, cnts, tcs, errs, b.cnt[7:0], b.tc, b.err);
      end
    end
  endtask

  task automatic test_load_clamp();
    exp_t a, b, c;
    logic [15:0] lvs[4] = '{16'h00A5, 16'h0000, 16'h0037, 16'hFA3C};
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, (i != 1), lvs[i]);
      get_exp(a, b, c);
      checks++;
      if (cnt2 !== a.cnt[7:0] || tc2 !== a.tc || err2 !== a.err) begin
        errors++;
        $display("FAIL load_clamp dut2 step %0d: cnt=%h tc=%b err=%b expected cnt=%h tc=%b err=%b",
                 i, cnt2, tc2, err2, a.cnt[7:0], a.tc, a.err);
      end
      checks++;
      if (cnt4 !== c.cnt[15:0] || tc4 !== c.tc || err4 !== c.err) begin
        errors++;
        $display("FAIL load_clamp dut4 step %0d: cnt=%h tc=%b err=%b expected cnt=%h tc=%b err=%b",
                 i, cnt4, tc4, err4, c.cnt[15:0], c.tc, c.err);
      end
    end
  endtask

  task automatic test_priority();
    exp_t a, b, c;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive(0, 0, 0, 1, 16'h0042);
        1: drive(1, 0, 1, 1, 16'h0077);
        default: drive(1, 0, 0, 1, 16'h0055);
      endcase
      get_exp(a, b, c);
      checks++;
      if (cnt2 !== a.cnt[7:0] || tc2 !== a.tc || err2 !== a.err) begin
        errors++;
        $display("FAIL priority step %0d: cnt=%h tc=%b err=%b expected cnt=%h tc=%b err=%b",
                 i, cnt2, tc2, err2, a.cnt[7:0], a.tc, a.err);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t a, b, c;
    drive(0, 0, 0, 1, 16'h0455);
    get_exp(a, b, c);
    drive(1, 0, 0, 0, 16'h0000);
    get_exp(a, b, c);
    drive(1, 0, 0, 0, 16'h0000);
    get_exp(a, b, c);
    checks++;
    if (cnt4 !== c.cnt[15:0]) begin
      errors++; $display("FAIL async_pre: cnt=%h expected %h", cnt4, c.cnt[15:0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (cnt4 !== 16'h0000 || tc4 !== 1'b0 || err4 !== 1'b0) begin
      errors++; $display("FAIL async_reset: cnt=%h tc=%b err=%b expected 0000/0/0", cnt4, tc4, err4);
    end
    en = 0; load = 0; clr = 0;
    m2 = '0; ms = '0; m4 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 16'h0000);
    get_exp(a, b, c);
    checks++;
    if (cnt4 !== c.cnt[15:0] || tc4 !== c.tc || err4 !== c.err) begin
      errors++;
      $display("FAIL async_resume: cnt=%h tc=%b err=%b expected cnt=%h tc=%b err=%b",
               cnt4, tc4, err4, c.cnt[15:0], c.tc, c.err);
    end
  endtask

  task automatic test_back_to_back();
    exp_t a, b, c;
    logic e, uu, cl, ld;
    logic [15:0] lv;
    for (int i = 0; i < 80; i++) begin
      if (i == 0) begin
        e = 0; uu = 0; cl = 0; ld = 1; lv = 16'h0001;
      end else if (i < 8) begin
        e = 1; uu = (i < 3) || (i == 6); cl = 0; ld = 0; lv = '0;
      end else begin
        e  = ($urandom_range(0, 3) != 0);
        uu = 1'($urandom_range(0, 1));
        cl = ($urandom_range(0, 15) == 0);
        ld = ($urandom_range(0, 7) == 0);
        lv = 16'($urandom);
      end
      drive(e, uu, cl, ld, lv);
      get_exp(a, b, c);
      checks++;
      if (cnt2 !== a.cnt[7:0] || tc2 !== a.tc || err2 !== a.err) begin
        errors++;
        $display("FAIL b2b dut2 cyc %0d: cnt=%h tc=%b err=%b expected cnt=%h tc=%b err=%b",
                 i, cnt2, tc2, err2, a.cnt[7:0], a.tc, a.err);
      end
      checks++;
      if (cnts !== b.cnt[7:0] || tcs !== b.tc || errs !== b.err) begin
        errors++;
        $display("FAIL b2b duts cyc %0d: cnt=%h tc=%b err=%b expected cnt=%h tc=%b err=%b",
                 i, cnts, tcs, errs, b.cnt[7:0], b.tc, b.err);
      end
      checks++;
      if (cnt4 !== c.cnt[15:0] || tc4 !== c.tc || err4 !== c.err) begin
        errors++;
        $display("FAIL b2b dut4 cyc %0d: cnt=%h tc=%b err=%b expected cnt=%h tc=%b err=%b",
                 i, cnt4, tc4, err4, c.cnt[15:0], c.tc, c.err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load_clamp();
    test_priority();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
